// File: rtl/arith_seq_pkg.sv
// Shared encodings for the arithmetic-unit micro-sequencer: op codes, FSM states,
// command strobe indices and the per-state command decode.
package arith_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE  = 4'd0;
    localparam state_t ST_S1    = 4'd1;
    localparam state_t ST_S2    = 4'd2;
    localparam state_t ST_S3    = 4'd3;
    localparam state_t ST_S4    = 4'd4;
    localparam state_t ST_TEST  = 4'd5;
    localparam state_t ST_SHIFT = 4'd6;
    localparam state_t ST_FIN   = 4'd7;
    localparam state_t ST_DONE  = 4'd8;

    localparam int STB_CLEAR_B = 0;
    localparam int STB_NOT_A   = 1;
    localparam int STB_SUM     = 2;
    localparam int STB_AND     = 3;
    localparam int STB_SHIFT   = 4;
    localparam int STB_C2A     = 5;
    localparam int STB_B2C     = 6;
    localparam int NUM_STB     = 7;

    typedef logic [NUM_STB-1:0] cmd_t;

    // Command issued while sitting in a given state; TEST decides its own command.
    function automatic cmd_t cmd_for(input logic [1:0] op, input state_t st);
        cmd_t cmd;
        cmd = '0;
        case (st)
            ST_S1: cmd[STB_C2A] = 1'b1;
            ST_S2: begin
                case (op)
                    OP_ADD:  cmd[STB_SUM]   = 1'b1;
                    OP_SUB:  cmd[STB_NOT_A] = 1'b1;
                    default: cmd[STB_B2C]   = 1'b1;
                endcase
            end
            ST_S3: begin
                case (op)
                    OP_ADD:  cmd[STB_B2C]     = 1'b1;
                    OP_SUB:  cmd[STB_SUM]     = 1'b1;
                    OP_AND:  cmd[STB_AND]     = 1'b1;
                    default: cmd[STB_CLEAR_B] = 1'b1;
                endcase
            end
            ST_S4:    cmd[STB_B2C]   = 1'b1;
            ST_SHIFT: cmd[STB_SHIFT] = 1'b1;
            ST_FIN:   cmd[STB_B2C]   = 1'b1;
            default:  cmd = '0;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/arith_seq_ctrl_mul_step_counter.sv
// Shift-step counter for the multiply loop: reload to zero at setup, count each
// shift, and flag the step whose shift is the last one.
module mul_step_counter #(
    parameter int CNT_W     = 5,
    parameter int MUL_STEPS = 30
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic inc,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(MUL_STEPS - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = '0;
        end else if (inc) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign last = (count_reg == LAST_VAL);

endmodule

// File: rtl/arith_seq_ctrl.sv
// Micro-sequencer issuing one arithmetic-unit command per cycle for ADD, SUB,
// AND and fractional MUL (high half of the product left in C).
module arith_seq_ctrl
    import arith_seq_pkg::*;
#(
    parameter int WIDTH     = 30,
    parameter int MUL_STEPS = WIDTH,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] op_sel,
    input  logic       carry_out_from_au,
    input  logic       reg_b0_from_au,
    input  logic       reg_c30_from_au,
    output logic       do_clear_b,
    output logic       do_not_a,
    output logic       do_sum,
    output logic       do_and,
    output logic       do_right_shift_bc,
    output logic       do_move_c_to_a,
    output logic       do_move_b_to_c,
    output logic       busy,
    output logic       done,
    output logic       flag
);

    state_t     state_reg, state_next;
    logic [1:0] op_reg, op_next;
    cmd_t       cmd_reg, cmd_next;
    logic       busy_reg, done_reg, flag_reg, flag_next;
    logic       cnt_load, cnt_inc, cnt_last;
    logic       test_sum, test_shift;
    logic       unused_carry;

    assign unused_carry = carry_out_from_au;

    mul_step_counter #(
        .CNT_W     (CNT_W),
        .MUL_STEPS (MUL_STEPS)
    ) u_step_cnt (
        .clk    (clk),
        .resetn (resetn),
        .load   (cnt_load),
        .inc    (cnt_inc),
        .last   (cnt_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_ADD;
            cmd_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            flag_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            cmd_reg   <= cmd_next;
            busy_reg  <= (state_next != ST_IDLE);
            done_reg  <= (state_next == ST_DONE);
            flag_reg  <= flag_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_S1;
                    op_next    = op_sel;
                end
            end
            ST_S1: state_next = ST_S2;
            ST_S2: state_next = ST_S3;
            ST_S3: begin
                if (op_reg == OP_SUB) begin
                    state_next = ST_S4;
                end else if (op_reg == OP_MUL) begin
                    state_next = ST_TEST;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_S4: state_next = ST_DONE;
            ST_TEST: begin
                if (reg_c30_from_au) begin
                    state_next = ST_SHIFT;
                end else if (cnt_last) begin
                    state_next = ST_FIN;
                end else begin
                    state_next = ST_TEST;
                end
            end
            ST_SHIFT: state_next = cnt_last ? ST_FIN : ST_TEST;
            ST_FIN:   state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // The multiplier bit only becomes visible after the previous shift lands, so
    // TEST chooses sum-or-shift in the same cycle to keep zero bits at one cycle each.
    always_comb begin
        cmd_next   = cmd_for(op_next, state_next);
        test_sum   = (state_reg == ST_TEST) && reg_c30_from_au;
        test_shift = (state_reg == ST_TEST) && !reg_c30_from_au;
        cnt_load   = (state_reg == ST_S3) && (op_reg == OP_MUL);
        cnt_inc    = (state_reg == ST_SHIFT) || test_shift;
        flag_next  = flag_reg;
        if ((state_reg == ST_IDLE) && start) begin
            flag_next = 1'b0;
        end else if ((state_reg == ST_S3) && (op_reg == OP_ADD)) begin
            flag_next = reg_b0_from_au;
        end else if ((state_reg == ST_S4) && (op_reg == OP_SUB)) begin
            flag_next = ~reg_b0_from_au;
        end
    end

    assign do_clear_b        = cmd_reg[STB_CLEAR_B];
    assign do_not_a          = cmd_reg[STB_NOT_A];
    assign do_sum            = cmd_reg[STB_SUM] | test_sum;
    assign do_and            = cmd_reg[STB_AND];
    assign do_right_shift_bc = cmd_reg[STB_SHIFT] | test_shift;
    assign do_move_c_to_a    = cmd_reg[STB_C2A];
    assign do_move_b_to_c    = cmd_reg[STB_B2C];
    assign busy              = busy_reg;
    assign done              = done_reg;
    assign flag              = flag_reg;

endmodule
